// File: rtl/serial_negate_rx_if.sv
// Serial-in / parallel-out handshake bundle for the serial negate receiver.
// Latency: n/a (wires only).
// Backpressure: sin_ready from the receiver; out_ready from the parallel consumer.
// Signals: sin/sin_valid/sin_start/sin_ready carry the LSB-first serial stream;
//          out_word/out_valid/out_ready/ovf carry the result word; frame_err flags aborts.
interface serial_negate_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sin_start;
    logic             sin_ready;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic             frame_err;

    // Receiver side.
    modport slave (
        input  sin, sin_valid, sin_start, out_ready,
        output sin_ready, out_word, out_valid, ovf, frame_err
    );

    // Serial producer plus parallel consumer side.
    modport master (
        output sin, sin_valid, sin_start, out_ready,
        input  sin_ready, out_word, out_valid, ovf, frame_err
    );
endinterface

// File: rtl/serial_negate_rx.sv
// Negates an LSB-first serial two's-complement word on the fly and deserialises it.
// Latency: out_valid rises one cycle after the last (WIDTH-th) bit is accepted.
// Backpressure: sin_ready drops while a result is held; word held until out_ready.
// Ports: clk, rst_n (sync active-low); bus.slave carries the serial input,
//        the parallel result handshake, ovf and the frame_err pulse.
module serial_negate_rx #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_negate_rx_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             out_valid_q;
    logic             ovf_q;
    logic             frame_err_q;

    logic accept;
    logic c_eff;
    logic res_bit;
    logic c_next;

    assign bus.sin_ready = (state != ST_HOLD);
    assign bus.out_word  = shreg;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.frame_err = frame_err_q;

    assign accept = bus.sin_valid && bus.sin_ready;

    // A start bit always begins with carry 1, whatever the flop holds from
    // an abandoned frame. Carry stays 1 until the first 1 bit passes, so
    // bits up to and including it are copied and later bits are inverted.
    assign c_eff   = bus.sin_start ? 1'b1 : carry;
    assign res_bit = ~bus.sin ^ c_eff;
    assign c_next  = ~bus.sin & c_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            carry       <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Bits without a start marker are dropped silently.
                    if (accept && bus.sin_start) begin
                        shreg <= {res_bit, shreg[WIDTH-1:1]};
                        carry <= c_next;
                        cnt   <= CW'(1);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        shreg <= {res_bit, shreg[WIDTH-1:1]};
                        carry <= c_next;
                        if (bus.sin_start) begin
                            // Restart: the partial frame is abandoned.
                            cnt         <= CW'(1);
                            frame_err_q <= 1'b1;
                        end else if (cnt == LAST_IDX) begin
                            // Carry into the MSB still 1 with raw MSB 1 means
                            // the input was the most negative value.
                            ovf_q       <= c_eff & bus.sin;
                            out_valid_q <= 1'b1;
                            cnt         <= '0;
                            state       <= ST_HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                        carry       <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_negate_rx.sv
// Randomised self-checking bench for serial_negate_rx against an arithmetic model.
// Latency: expects out_valid one cycle after the last serial bit.
// Backpressure: exercises held results, ignored serial input in hold, and gaps.
module tb_serial_negate_rx;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_frames;
    int   n_ov_rise;
    int   n_fe;
    logic prev_ov;

    serial_negate_rx_if #(.WIDTH(W)) bif ();

    serial_negate_rx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output events independently of the per-frame checks.
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
        end else begin
            if (bif.out_valid && !prev_ov) n_ov_rise <= n_ov_rise + 1;
            if (bif.frame_err) n_fe <= n_fe + 1;
            prev_ov <= bif.out_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        bif.sin       = b;
        bif.sin_valid = 1'b1;
        bif.sin_start = st;
        tick();
        bif.sin_valid = 1'b0;
        bif.sin_start = 1'b0;
    endtask

    // Reference: the result is the two's-complement negation modulo 2^W;
    // overflow only for the most negative value.
    task automatic send_frame(input logic [W-1:0] raw, input int gap_at, input int gap_len,
                              input bit abort_exp, input int hold);
        logic [W-1:0] exp_w;
        logic         exp_ovf;
        exp_w   = W'(0) - raw;
        exp_ovf = (raw == W'(1) << (W - 1));
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bif.sin_valid = 1'b0;
                    bif.sin       = 1'($urandom);
                    bif.sin_start = 1'($urandom);
                    tick();
                    chk("gap_out_valid", 32'(bif.out_valid), 32'd0);
                end
            end
            send_bit(raw[i], i == 0);
            chk("frame_err", 32'(bif.frame_err), 32'((i == 0) && abort_exp));
            if (i < W - 1) chk("early_out_valid", 32'(bif.out_valid), 32'd0);
        end
        n_frames++;
        chk("out_valid", 32'(bif.out_valid), 32'd1);
        chk("out_word", 32'(bif.out_word), 32'(exp_w));
        chk("ovf", 32'(bif.ovf), 32'(exp_ovf));
        chk("hold_sin_ready", 32'(bif.sin_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bif.sin_valid = 1'b1;
            bif.sin       = 1'($urandom);
            bif.sin_start = 1'($urandom);
            tick();
            chk("hold_out_valid", 32'(bif.out_valid), 32'd1);
            chk("hold_out_word", 32'(bif.out_word), 32'(exp_w));
            chk("hold_ovf", 32'(bif.ovf), 32'(exp_ovf));
            chk("hold_sin_ready", 32'(bif.sin_ready), 32'd0);
            chk("hold_frame_err", 32'(bif.frame_err), 32'd0);
        end
        bif.sin_valid = 1'b0;
        bif.sin_start = 1'b0;
        bif.out_ready = 1'b1;
        tick();
        bif.out_ready = 1'b0;
        chk("release_out_valid", 32'(bif.out_valid), 32'd0);
        chk("release_ovf", 32'(bif.ovf), 32'd0);
        chk("release_sin_ready", 32'(bif.sin_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_frames = 0;
        n_ov_rise = 0;
        n_fe = 0;
        bif.sin = 1'b0;
        bif.sin_valid = 1'b0;
        bif.sin_start = 1'b0;
        bif.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_out_word", 32'(bif.out_word), 32'd0);
        chk("rst_ovf", 32'(bif.ovf), 32'd0);
        chk("rst_frame_err", 32'(bif.frame_err), 32'd0);
        chk("rst_sin_ready", 32'(bif.sin_ready), 32'd1);
        rst_n = 1'b1;

        // Directed cases.
        send_frame(4'b0011, -1, 0, 1'b0, 0);
        send_frame(4'b0000, -1, 0, 1'b0, 0);
        send_frame(4'b1000, -1, 0, 1'b0, 0);
        send_frame(4'b0111, -1, 0, 1'b0, 0);
        send_frame(4'b0110, 2, 3, 1'b0, 0);

        // Non-start bits in idle are dropped.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("idle_drop_out_valid", 32'(bif.out_valid), 32'd0);
        chk("idle_drop_frame_err", 32'(bif.frame_err), 32'd0);

        // Abort mid-frame by a new start.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_frame(4'b0001, -1, 0, 1'b1, 0);

        // Long hold with serial activity ignored, then a follow-on frame.
        send_frame(4'b1100, -1, 0, 1'b0, 5);
        send_frame(4'b0101, -1, 0, 1'b0, 0);

        // Reset mid-frame discards the partial word.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("midrst_sin_ready", 32'(bif.sin_ready), 32'd1);
        send_frame(4'b0010, -1, 0, 1'b0, 0);

        // Randomised frames with random gaps and hold times.
        for (int k = 0; k < 40; k++) begin
            send_frame(W'($urandom_range(0, (1 << W) - 1)),
                       int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)),
                       1'b0, int'($urandom_range(0, 3)));
        end

        tick();
        chk("out_valid_rises", 32'(n_ov_rise), 32'(n_frames));
        chk("frame_err_pulses", 32'(n_fe), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_negate_rx.md
Name: serial_negate_rx

Overview:
- Receive end of the serial two's-complement path. Accepts an LSB-first serial bit stream one bit per valid cycle.
- Negates the stream on the fly: copy bits up to and including the first 1, invert every bit after it.
- Deserialises the result into a parallel word and presents it on a valid/ready output handshake.
- Sits downstream of the serial shift-out datapath and returns results to the parallel domain.

Parameters:
- WIDTH, 4, word length in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- sin  input  1  serial data bit, LSB first.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_start  input  1  qualifies the current bit as bit 0 of a frame; only meaningful with sin_valid.
- sin_ready  output  1  block accepts serial bits; high in IDLE and SHIFT, low in HOLD.
- out_word  output  WIDTH  negated word, bit i = result bit i.
- out_valid  output  1  out_word valid; held until accepted.
- out_ready  input  1  consumer accepts out_word.
- ovf  output  1  valid with out_valid; input word was the most negative value (1 followed by WIDTH-1 zeros).
- frame_err  output  1  one-cycle pulse; a frame was aborted by sin_start mid-frame.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset state:
  - State IDLE; shift register, bit counter, out_word, out_valid, ovf and frame_err all 0; carry flop = 1.
  - sin_ready = 1 from the first cycle after reset.
  - Reset mid-frame or in HOLD discards all data, with no out_valid.
- A bit is accepted when sin_valid && sin_ready.
- Per-bit arithmetic, with c = carry flop:
  - result = ~sin ^ c; c_next = ~sin & c.
  - A sin_start bit uses c = 1 regardless of the flop contents.
- Deserialiser:
  - WIDTH-bit register shifts right; each result bit enters at the MSB.
  - After WIDTH accepted bits, bit 0 of the word sits at the LSB.
- States:
  - IDLE:
    - A bit with sin_start=1 is processed as bit 0; counter = 1; go to SHIFT.
    - A bit with sin_start=0 is dropped with no flag.
    - sin_valid=0 holds the state.
  - SHIFT:
    - Each accepted bit increments the counter.
    - sin_valid=0 is a stall: no state, counter or carry change; gaps of any length are legal.
    - When the accepted bit is bit WIDTH-1, go to HOLD. On the next cycle out_valid=1 and out_word holds the final value.
    - Latency: out_valid rises one cycle after the last bit is accepted.
  - Abort in SHIFT:
    - An accepted bit with sin_start=1 abandons the partial frame.
    - That bit is processed as bit 0 of a new frame; counter = 1; stay in SHIFT.
    - frame_err pulses high for exactly one cycle, the cycle after.
  - HOLD:
    - sin_ready = 0; serial input is ignored, and no stall bookkeeping is needed.
    - out_word and ovf stay stable while out_valid && !out_ready.
    - When out_valid && out_ready: return to IDLE next cycle; out_valid, ovf and the carry flop return to 0, 0 and 1.
- ovf computation:
  - ovf = 1 iff the carry into the MSB is 1 and raw bit WIDTH-1 is 1.
  - The result then equals the input, 1 followed by WIDTH-1 zeros.
  - An all-zero input gives result 0 with ovf = 0.
- With WIDTH=2, the first accepted bit may also be the last-but-one; no special case is allowed.

Test Plan:
- WIDTH=4, raw 0011 sent LSB first (sin 1,1,0,0) on four consecutive valid cycles, start on the first -> one cycle after the 4th bit: out_valid=1, out_word=1101, ovf=0.
- Raw 0000 (sin 0,0,0,0) -> out_word=0000, ovf=0. Raw 1000 (sin 0,0,0,1) -> out_word=1000, ovf=1. Raw 0111 -> out_word=1001.
- Raw 0110 with sin_valid low for 3 cycles between bits 1 and 2 -> out_word=1010; out_valid rises exactly one cycle after the 4th accepted bit.
- Send bits 1,0 of a frame, then a new start with raw 0001 -> frame_err pulses once; out_word=1111; only one out_valid.
- Hold out_ready=0 for 5 cycles after out_valid -> out_word and out_valid stable, sin_ready=0, serial bits during HOLD ignored. Raise out_ready -> next cycle out_valid=0, sin_ready=1; a following raw 0101 frame gives 1011.
- Assert rst_n=0 for one cycle after 2 bits, then send a full raw 0010 frame -> no output from the aborted frame; out_word=1110, ovf=0.
